// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, constants and jump-table contents for the fetch stage
package fetch_pkg;

  localparam int PC_W      = 8;
  localparam int INSTR_W   = 9;
  localparam int LUT_IDX_W = 4;
  localparam int LUT_DEPTH = 16;

  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'b111111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Jump targets per problem; regenerated by the assembler
  localparam logic [PC_W-1:0] JT_P0 [0:LUT_DEPTH-1] = '{
    8'd3,   8'd17,  8'd29,  8'd44,  8'd58,  8'd63,  8'd71,  8'd88,
    8'd96,  8'd105, 8'd117, 8'd130, 8'd142, 8'd150, 8'd199, 8'd250
  };

  localparam logic [PC_W-1:0] JT_P1 [0:LUT_DEPTH-1] = '{
    8'd12,  8'd25,  8'd33,  8'd40,  8'd52,  8'd66,  8'd79,  8'd81,
    8'd93,  8'd110, 8'd121, 8'd128, 8'd160, 8'd177, 8'd201, 8'd230
  };

  localparam logic [PC_W-1:0] JT_P2 [0:LUT_DEPTH-1] = '{
    8'd2,   8'd9,   8'd20,  8'd31,  8'd47,  8'd55,  8'd68,  8'd77,
    8'd99,  8'd111, 8'd123, 8'd140, 8'd155, 8'd170, 8'd222, 8'd254
  };

endpackage

// File: rtl/jump_lut.sv
// rtl/jump_lut.sv - combinational jump-table lookup by problem bank and index
module jump_lut #(
  parameter int PC_W      = fetch_pkg::PC_W,
  parameter int LUT_IDX_W = fetch_pkg::LUT_IDX_W
) (
  input  logic [1:0]           problem_number,
  input  logic [LUT_IDX_W-1:0] branch_idx,
  output logic [PC_W-1:0]      target
);
  import fetch_pkg::*;

  logic [fetch_pkg::PC_W-1:0] w_entry;

  // Bank 11 has no program and reads as all zeros
  always_comb begin
    w_entry = '0;
    case (problem_number)
      2'b00:   w_entry = JT_P0[branch_idx];
      2'b01:   w_entry = JT_P1[branch_idx];
      2'b10:   w_entry = JT_P2[branch_idx];
      default: w_entry = '0;
    endcase
  end

  assign target = PC_W'(w_entry);

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter, branch application and IDLE/RUN/DONE fetch control
module fetch_sequencer #(
  parameter int                   PC_W       = fetch_pkg::PC_W,
  parameter int                   INSTR_W    = fetch_pkg::INSTR_W,
  parameter int                   CNT_W      = 16,
  parameter int                   LUT_IDX_W  = fetch_pkg::LUT_IDX_W,
  parameter logic [INSTR_W-1:0]   HALT_INSTR = fetch_pkg::HALT_INSTR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           problem_number,
  input  logic                 start,
  input  logic                 stall,
  input  logic [INSTR_W-1:0]   instr,
  input  logic                 branch_en,
  input  logic                 branch_rel,
  input  logic [PC_W-1:0]      branch_off,
  input  logic [LUT_IDX_W-1:0] branch_idx,
  output logic [PC_W-1:0]      pc,
  output logic                 fetch_valid,
  output logic                 done,
  output logic                 pc_wrap,
  output logic [CNT_W-1:0]     instr_count
);
  import fetch_pkg::*;

  state_t           r_state, w_state_nxt;
  logic [PC_W-1:0]  r_pc, w_pc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_wrap, w_wrap_nxt;
  logic [PC_W-1:0]  w_lut_target;

  jump_lut #(
    .PC_W      (PC_W),
    .LUT_IDX_W (LUT_IDX_W)
  ) u_jump_lut (
    .problem_number (problem_number),
    .branch_idx     (branch_idx),
    .target         (w_lut_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_wrap_nxt  = r_wrap;
    case (r_state)
      IDLE, DONE: begin
        if (r_state == IDLE) w_pc_nxt = '0;
        if (start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = '0;
          w_cnt_nxt   = '0;
          w_wrap_nxt  = 1'b0;
        end
      end
      RUN: begin
        // A stalled cycle retires nothing and decides nothing
        if (!stall) begin
          if (r_cnt != '1) w_cnt_nxt = r_cnt + 1'b1;
          if (instr == HALT_INSTR) begin
            w_state_nxt = DONE;
          end else if (branch_en && branch_rel) begin
            w_pc_nxt = r_pc + branch_off;
          end else if (branch_en) begin
            w_pc_nxt = w_lut_target;
          end else begin
            w_pc_nxt = r_pc + 1'b1;
            if (r_pc == '1) w_wrap_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_pc_nxt    = '0;
      end
    endcase
  end

  assign pc          = r_pc;
  assign fetch_valid = (r_state == RUN);
  assign done        = (r_state == DONE);
  assign pc_wrap     = r_wrap;
  assign instr_count = r_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed and randomized checks of fetch_sequencer against a behavioural model
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] prob;
  logic       start, stall, ben, brel;
  logic [7:0] boff;
  logic [3:0] bidx;
  logic [8:0] instr, instr4;

  logic [7:0]  pc, pc4;
  logic        fv, fv4, done, done4, wrap, wrap4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  logic [8:0] rom [256];
  int jt [4][16];

  int n_tests = 0;
  int n_fail  = 0;

  int m_st, m_pc, m_cnt, m_cnt4, m_wrap;

  always #5 clk = ~clk;

  assign instr  = rom[pc];
  assign instr4 = rom[pc4];

  fetch_sequencer dut (
    .clk (clk), .rst_n (rst_n), .problem_number (prob), .start (start), .stall (stall),
    .instr (instr), .branch_en (ben), .branch_rel (brel), .branch_off (boff), .branch_idx (bidx),
    .pc (pc), .fetch_valid (fv), .done (done), .pc_wrap (wrap), .instr_count (cnt)
  );

  fetch_sequencer #(.CNT_W(4)) dut4 (
    .clk (clk), .rst_n (rst_n), .problem_number (prob), .start (start), .stall (stall),
    .instr (instr4), .branch_en (ben), .branch_rel (brel), .branch_off (boff), .branch_idx (bidx),
    .pc (pc4), .fetch_valid (fv4), .done (done4), .pc_wrap (wrap4), .instr_count (cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc", 32'(pc), m_pc);
    chk("fetch_valid", 32'(fv), (m_st == 1) ? 1 : 0);
    chk("done", 32'(done), (m_st == 2) ? 1 : 0);
    chk("pc_wrap", 32'(wrap), m_wrap);
    chk("instr_count", 32'(cnt), m_cnt);
    chk("pc_w4", 32'(pc4), m_pc);
    chk("instr_count_w4", 32'(cnt4), m_cnt4);
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = 0; m_cnt = 0; m_cnt4 = 0; m_wrap = 0;
  endtask

  task automatic model_step();
    int ins, off;
    ins = int'(rom[m_pc]);
    off = (boff >= 8'd128) ? int'(boff) - 256 : int'(boff);
    if (m_st != 1) begin
      if (start) begin
        m_st = 1; m_pc = 0; m_cnt = 0; m_cnt4 = 0; m_wrap = 0;
      end
    end else if (!stall) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
      if (ins == 511) m_st = 2;
      else if (ben && brel) m_pc = (m_pc + off + 256) % 256;
      else if (ben) m_pc = jt[prob][bidx];
      else begin
        if (m_pc == 255) m_wrap = 1;
        m_pc = (m_pc + 1) % 256;
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic quiet();
    start = 0; stall = 0; ben = 0; brel = 0; boff = 0; bidx = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    jt[0] = '{3, 17, 29, 44, 58, 63, 71, 88, 96, 105, 117, 130, 142, 150, 199, 250};
    jt[1] = '{12, 25, 33, 40, 52, 66, 79, 81, 93, 110, 121, 128, 160, 177, 201, 230};
    jt[2] = '{2, 9, 20, 31, 47, 55, 68, 77, 99, 111, 123, 140, 155, 170, 222, 254};
    jt[3] = '{default: 0};
    for (int i = 0; i < 256; i++) rom[i] = 9'h000;
    rst_n = 1'b0;
    prob = 2'b00;
    quiet();
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // HALT at address 5
    rom[5] = 9'h1FF;
    start = 1; cyc(); start = 0;
    repeat (6) cyc();
    chk("halt_done", 32'(done), 1);
    chk("halt_count", 32'(cnt), 6);
    chk("halt_pc", 32'(pc), 5);
    chk("halt_fv", 32'(fv), 0);
    cyc();
    rom[5] = 9'h000;

    // Relative branches
    start = 1; cyc(); start = 0;
    repeat (10) cyc();
    ben = 1; brel = 1; boff = 8'hFB; cyc();
    chk("rel_back5", 32'(pc), 5);
    boff = 8'hFD; cyc();
    boff = 8'hFB; cyc();
    chk("rel_wrap_pc", 32'(pc), 253);
    chk("rel_wrap_flag", 32'(wrap), 0);

    // Jump table
    boff = 8'd10; cyc();
    chk("rel_fwd7", 32'(pc), 7);
    prob = 2'b01; brel = 0; bidx = 4'd3; cyc();
    chk("jt_p1_i3", 32'(pc), 40);
    prob = 2'b11; cyc();
    chk("jt_p3_zero", 32'(pc), 0);

    // Stall beats HALT beats branch
    rom[0] = 9'h1FF;
    stall = 1; ben = 1; brel = 1; boff = 8'd5;
    repeat (4) begin
      cyc();
      chk("stall_nodone", 32'(done), 0);
    end
    stall = 0; cyc();
    chk("halt_over_branch", 32'(done), 1);
    chk("halt_over_branch_pc", 32'(pc), 0);
    quiet(); rom[0] = 9'h000; prob = 2'b00;

    // Stall ignored in DONE
    stall = 1; start = 1; cyc();
    chk("restart_from_done", 32'(fv), 1);
    quiet();

    // Long straight-line run: wrap and 4-bit saturation
    repeat (300) cyc();
    chk("wrap_sticky", 32'(wrap), 1);
    chk("wrap_pc", 32'(pc), 44);
    chk("count300", 32'(cnt), 300);
    chk("sat4", 32'(cnt4), 15);

    // Async reset between edges at pc 30
    ben = 1; brel = 1; boff = 8'hF2; cyc(); quiet();
    chk("pc30", 32'(pc), 30);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_all();
    start = 1; cyc(); start = 0;
    chk("post_reset_run", 32'(fv), 1);
    cyc();
    chk("post_reset_pc1", 32'(pc), 1);

    // Randomized traffic
    for (int i = 0; i < 256; i++)
      rom[i] = ($urandom_range(0, 31) == 0) ? 9'h1FF : 9'($urandom_range(0, 510));
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 4) == 0);
      ben   = ($urandom_range(0, 3) == 0);
      brel  = 1'($urandom_range(0, 1));
      boff  = 8'($urandom_range(0, 255));
      bidx  = 4'($urandom_range(0, 15));
      if (m_st != 1) prob = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and fetch-control stage directly upstream of the instruction ROM.
- Holds `pc`, steps it each cycle, and applies branches (relative offset or per-problem jump-table target).
- Detects the HALT word returning from the ROM and runs an IDLE/RUN/DONE handshake with the testbench/top level.
- Counts executed instructions for performance reporting.

Parameters:
- PC_W, 8, program counter / ROM address width
- INSTR_W, 9, instruction width returned by ROM
- CNT_W, 16, executed-instruction counter width
- LUT_IDX_W, 4, jump-table index width (16 entries per problem)
- HALT_INSTR, 9'b111111111, encoding that terminates a program

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- problem_number  in  2  selects jump-table bank (00, 01, 10; 11 = bank of zeros); must be stable while in RUN
- start  in  1  single-cycle request to begin execution at pc 0
- stall  in  1  hold all state this cycle (downstream multi-cycle op)
- instr  in  INSTR_W  current instruction from ROM (combinational function of pc)
- branch_en  in  1  decode says branch taken this cycle
- branch_rel  in  1  1 = pc-relative offset, 0 = jump-table target
- branch_off  in  PC_W  signed two's-complement offset (used when branch_rel=1)
- branch_idx  in  LUT_IDX_W  jump-table index (used when branch_rel=0)
- pc  out  PC_W  address to ROM
- fetch_valid  out  1  instr is a live instruction this cycle
- done  out  1  program halted; held until next start
- pc_wrap  out  1  sticky: sequential increment wrapped 255->0
- instr_count  out  CNT_W  instructions retired in current run

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=0, done=0, fetch_valid=0, pc_wrap=0, instr_count=0.
  - Release is sampled at the next rising edge.
- States are IDLE, RUN and DONE. fetch_valid is 1 iff state==RUN. done is 1 iff state==DONE.
- IDLE:
  - pc held at 0.
  - start=1 -> RUN next cycle with pc=0, instr_count=0, pc_wrap=0.
- RUN, per rising edge, priority high to low:
  1. stall=1: pc, instr_count and state hold. HALT/branch are not evaluated.
  2. instr==HALT_INSTR: state->DONE, pc holds, instr_count+1.
  3. branch_en=1, branch_rel=1: pc <= pc + branch_off, computed modulo 2^PC_W. Wrap here does not set pc_wrap. instr_count+1.
  4. branch_en=1, branch_rel=0: pc <= jump_table[problem_number][branch_idx]. instr_count+1.
  5. Otherwise: pc <= pc+1. If pc==2^PC_W-1, pc becomes 0 and pc_wrap <= 1. instr_count+1.
- start is ignored in RUN.
- instr_count saturates at all-ones; it never wraps.
- DONE:
  - pc, instr_count and pc_wrap hold.
  - start=1 -> RUN with pc=0, counters cleared, done drops the same edge.
  - stall is ignored in DONE.
- Latency:
  - pc update takes effect one cycle after the deciding inputs.
  - The ROM is combinational, so the new instr is available in the same cycle as the new pc.
- Reset asserted mid-RUN: immediate return to IDLE values. No partial count is retained.
- HALT at pc 0 on the first RUN cycle: DONE after one cycle with instr_count=1.

Decomposition:
- Shared package fetch_pkg:
  - state enum {IDLE, RUN, DONE}
  - HALT_INSTR constant
  - PC_W, INSTR_W, LUT_IDX_W constants
  - jump-table contents as constant arrays per problem
- One sub-module, jump_lut:
  - Combinational (problem_number, branch_idx) -> PC_W target.
  - Kept separate so the assembler can regenerate its tables independently.

Test Plan:
- Reset then start: rst_n low 3 cycles, start pulse, ROM filled with NOP except HALT at addr 5 -> pc steps 0..5, done=1 on the cycle after pc=5, instr_count=6, fetch_valid low in DONE.
- Relative branch: at pc=10, branch_en=1, branch_rel=1, branch_off=8'hFB (-5) -> pc=5 next cycle. At pc=2 with offset -5 -> pc=253, pc_wrap stays 0.
- Jump table: problem_number=01, table[1][3]=8'd40, at pc=7 drive branch_en=1, branch_rel=0, branch_idx=3 -> pc=40. Same with problem_number=11 -> pc=0.
- Stall and priority: stall=1 for 4 cycles while instr==HALT and branch_en=1 -> pc and instr_count unchanged, no DONE. Release stall -> DONE next cycle (halt beats branch).
- Wrap and saturation: straight-line run from pc=0 with no HALT for 300 cycles -> pc goes 255->0, pc_wrap=1 sticky. Force CNT_W=4: instr_count stops at 15.
- Async reset mid-run: rst_n low between clock edges at pc=30 -> pc=0, state IDLE, done=0, instr_count=0 immediately. A later start restarts at pc 0.
